// File: rtl/snd_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snd_mailbox_pkg
// Brief    : Shared width helpers and NMI priority encoding for snd_mailbox.
// Revision : 1.0
// ============================================================================
package snd_mailbox_pkg;

    // Highest-priority cause wins in a given cycle; NMI_HOLD keeps the state.
    typedef enum logic [1:0] {
        NMI_HOLD      = 2'd0,
        NMI_SET_WR    = 2'd1,
        NMI_SET_REARM = 2'd2,
        NMI_CLR_ACK   = 2'd3
    } nmi_prio_e;

    function automatic int clog2_depth(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2_depth(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mailbox_fifo
// Brief    : Circular command buffer with registered head output, occupancy
//            count and sticky overflow flag.
// Revision : 1.0
// ============================================================================
module mailbox_fifo
    import snd_mailbox_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          wr,
    input  logic [DW-1:0]                 din,
    input  logic                          rd,
    output logic [DW-1:0]                 dout,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          wr_accept,
    output logic                          rd_accept
);

    localparam int c_PW = ptr_width(DEPTH);
    localparam int c_CW = cnt_width(DEPTH);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [DW-1:0]   r_dout;
    logic            r_ovf;

    logic [c_PW-1:0] w_rd_ptr_inc;
    logic [DW-1:0]   w_dout_nxt;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_drop;

    always_comb begin
        w_rd_acc     = rd && (r_count != '0) && !clr;
        w_wr_acc     = wr && ((r_count != c_FULL) || w_rd_acc) && !clr;
        w_drop       = wr && !w_wr_acc && !clr;
        w_rd_ptr_inc = r_rd_ptr + c_PW'(1);
        w_dout_nxt   = r_dout;
        // With one entry left, a pop exposes the slot being written this cycle.
        if (w_rd_acc) begin
            if (r_count > c_ONE) begin
                w_dout_nxt = r_mem[w_rd_ptr_inc];
            end else if (w_wr_acc) begin
                w_dout_nxt = din;
            end
        end else if (w_wr_acc && (r_count == '0)) begin
            w_dout_nxt = din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dout      = r_dout;
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign overflow  = r_ovf;
    assign count     = r_count;
    assign wr_accept = w_wr_acc;
    assign rd_accept = w_rd_acc;

endmodule
`default_nettype wire

// File: rtl/snd_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : snd_mailbox
// Brief    : Main-CPU to sound-CPU command mailbox with NMI request and
//            optional reply latch (enabled by SND_MAILBOX_REPLY_EN).
// Revision : 1.0
// ============================================================================
module snd_mailbox
    import snd_mailbox_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DW        = 8,
    parameter int NMI_REARM = 1
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          m_wr,
    input  logic [DW-1:0]                 m_din,
    output logic                          m_full,
    output logic                          overflow,
    input  logic                          s_rd,
    output logic [DW-1:0]                 s_dout,
    output logic                          s_empty,
    output logic                          s_nmi,
    input  logic                          s_int_ack,
`ifdef SND_MAILBOX_REPLY_EN
    input  logic                          r_wr,
    input  logic [DW-1:0]                 r_din,
    input  logic                          m_rd,
    output logic [DW-1:0]                 m_rdata,
    output logic                          m_reply_valid,
`endif
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int c_CW = cnt_width(DEPTH);

    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [c_CW-1:0] w_count;
    nmi_prio_e       w_nmi_cause;
    logic            r_nmi;

    mailbox_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .clr       (clr),
        .wr        (m_wr),
        .din       (m_din),
        .rd        (s_rd),
        .dout      (s_dout),
        .full      (m_full),
        .empty     (s_empty),
        .overflow  (overflow),
        .count     (w_count),
        .wr_accept (w_wr_acc),
        .rd_accept (w_rd_acc)
    );

    // A pop without a write leaves entries behind only if two or more were held.
    always_comb begin
        w_nmi_cause = NMI_HOLD;
        if (w_wr_acc) begin
            w_nmi_cause = NMI_SET_WR;
        end else if ((NMI_REARM != 0) && w_rd_acc && (w_count > c_CW'(1))) begin
            w_nmi_cause = NMI_SET_REARM;
        end else if (s_int_ack) begin
            w_nmi_cause = NMI_CLR_ACK;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_nmi <= 1'b0;
        end else if (clr) begin
            r_nmi <= 1'b0;
        end else begin
            case (w_nmi_cause)
                NMI_SET_WR,
                NMI_SET_REARM: r_nmi <= 1'b1;
                NMI_CLR_ACK:   r_nmi <= 1'b0;
                default:       r_nmi <= r_nmi;
            endcase
        end
    end

    assign s_nmi = r_nmi;
    assign count = w_count;

`ifdef SND_MAILBOX_REPLY_EN
    logic [DW-1:0] r_rdata;
    logic          r_valid;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else if (r_wr) begin
            r_rdata <= r_din;
            r_valid <= 1'b1;
        end else if (m_rd) begin
            r_valid <= 1'b0;
        end
    end

    assign m_rdata       = r_rdata;
    assign m_reply_valid = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snd_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_snd_mailbox
// Brief    : Scoreboard bench for snd_mailbox, NMI_REARM=1 and =0 side by side.
// Revision : 1.0
// ============================================================================
module tb_snd_mailbox;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          clr;
    logic          m_wr;
    logic [DW-1:0] m_din;
    logic          s_rd;
    logic          s_int_ack;

    logic          m_full, overflow, s_empty, s_nmi;
    logic [DW-1:0] s_dout;
    logic [2:0]    count;
    logic          m_full0, overflow0, s_empty0, s_nmi0;
    logic [DW-1:0] s_dout0;
    logic [2:0]    count0;

`ifdef SND_MAILBOX_REPLY_EN
    logic          r_wr;
    logic [DW-1:0] r_din;
    logic          m_rd;
    logic [DW-1:0] m_rdata, m_rdata0;
    logic          m_reply_valid, m_reply_valid0;
`endif

    snd_mailbox #(.DEPTH(DEPTH), .DW(DW), .NMI_REARM(1)) dut (
        .clk_sys (clk_sys), .reset (reset), .clr (clr),
        .m_wr (m_wr), .m_din (m_din), .m_full (m_full), .overflow (overflow),
        .s_rd (s_rd), .s_dout (s_dout), .s_empty (s_empty), .s_nmi (s_nmi),
        .s_int_ack (s_int_ack),
`ifdef SND_MAILBOX_REPLY_EN
        .r_wr (r_wr), .r_din (r_din), .m_rd (m_rd),
        .m_rdata (m_rdata), .m_reply_valid (m_reply_valid),
`endif
        .count (count)
    );

    snd_mailbox #(.DEPTH(DEPTH), .DW(DW), .NMI_REARM(0)) dut0 (
        .clk_sys (clk_sys), .reset (reset), .clr (clr),
        .m_wr (m_wr), .m_din (m_din), .m_full (m_full0), .overflow (overflow0),
        .s_rd (s_rd), .s_dout (s_dout0), .s_empty (s_empty0), .s_nmi (s_nmi0),
        .s_int_ack (s_int_ack),
`ifdef SND_MAILBOX_REPLY_EN
        .r_wr (r_wr), .r_din (r_din), .m_rd (m_rd),
        .m_rdata (m_rdata0), .m_reply_valid (m_reply_valid0),
`endif
        .count (count0)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_last;
    bit            m_nmi1, m_nmi0, m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_nmi1 = 1'b0;
        m_nmi0 = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_count",  32'(count),    32'd0);
        check("rst_empty",  32'(s_empty),  32'd1);
        check("rst_full",   32'(m_full),   32'd0);
        check("rst_nmi",    32'(s_nmi),    32'd0);
        check("rst_ovf",    32'(overflow), 32'd0);
        check("rst_dout",   32'(s_dout),   32'd0);
        check("rst_nmi0",   32'(s_nmi0),   32'd0);
`ifdef SND_MAILBOX_REPLY_EN
        check("rst_rdata",  32'(m_rdata),       32'd0);
        check("rst_rvalid", 32'(m_reply_valid), 32'd0);
`endif
    endtask

    // One clock of stimulus: model update, drive, clock, compare.
    task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit rd,
                       input bit ack, input bit fl);
        bit pop;
        bit acc;
        if (rd && (q.size() > 0) && !fl) begin
            check("pop_data", 32'(s_dout), 32'(q[0]));
        end
        m_wr = wr; m_din = d; s_rd = rd; s_int_ack = ack; clr = fl;
        if (fl) begin
            if (q.size() > 0) m_last = q[0];
            q.delete();
            m_nmi1 = 1'b0; m_nmi0 = 1'b0; m_ovf = 1'b0;
        end else begin
            pop = rd && (q.size() > 0);
            acc = wr && ((q.size() < DEPTH) || pop);
            if (wr && !acc) m_ovf = 1'b1;
            if (pop) m_last = q.pop_front();
            if (acc) q.push_back(d);
            if (acc || (pop && (q.size() >= 1))) m_nmi1 = 1'b1;
            else if (ack) m_nmi1 = 1'b0;
            if (acc) m_nmi0 = 1'b1;
            else if (ack) m_nmi0 = 1'b0;
        end
        tick();
        m_wr = 1'b0; s_rd = 1'b0; s_int_ack = 1'b0; clr = 1'b0;
        check("count",    32'(count),    32'(q.size()));
        check("empty",    32'(s_empty),  32'(q.size() == 0));
        check("full",     32'(m_full),   32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("nmi",      32'(s_nmi),    32'(m_nmi1));
        check("nmi_norearm", 32'(s_nmi0), 32'(m_nmi0));
        check("dout",     32'(s_dout),   32'((q.size() > 0) ? q[0] : m_last));
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; m_wr = 1'b0; m_din = '0; s_rd = 1'b0; s_int_ack = 1'b0;
`ifdef SND_MAILBOX_REPLY_EN
        r_wr = 1'b0; r_din = '0; m_rd = 1'b0;
`endif
        model_reset();
        #2;
        check_reset_values();
        tick();
        tick();
        reset = 1'b0;

        // Basic ordering
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        repeat (3) cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);                 // pop on empty is ignored

        // Overflow on fifth write
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        cyc(1, 8'h44, 0, 0, 0);
        cyc(1, 8'h55, 0, 0, 0);
        repeat (4) cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);

        // Write plus pop while full
        for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'hAA, 1, 0, 0);
        repeat (4) cyc(0, 8'h00, 1, 0, 0);

        // Write plus pop while empty: write only
        cyc(1, 8'h77, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);

        // NMI re-arm, acknowledge, set-beats-ack
        cyc(1, 8'hA1, 0, 0, 0);
        cyc(1, 8'hA2, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(1, 8'hA3, 0, 1, 0);
        repeat (2) cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            cyc(0, 8'h00, 1, 0, 0);
        end

        // Flush, including a same-cycle write and read that must be discarded
        cyc(1, 8'hC1, 0, 0, 0);
        cyc(1, 8'hC2, 0, 0, 0);
        cyc(1, 8'hC3, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);

`ifdef SND_MAILBOX_REPLY_EN
        r_wr = 1'b1; r_din = 8'h5A;
        tick();
        r_wr = 1'b0;
        check("reply_data",  32'(m_rdata),       32'h5A);
        check("reply_valid", 32'(m_reply_valid), 32'd1);
        m_rd = 1'b1;
        tick();
        m_rd = 1'b0;
        check("reply_rd_valid", 32'(m_reply_valid), 32'd0);
        check("reply_rd_hold",  32'(m_rdata),       32'h5A);
        r_wr = 1'b1; r_din = 8'h3C; m_rd = 1'b1;
        tick();
        r_wr = 1'b0; m_rd = 1'b0;
        check("reply_both_valid", 32'(m_reply_valid), 32'd1);
        check("reply_both_data",  32'(m_rdata),       32'h3C);
`endif

        // Asynchronous reset in the middle of a write burst
        cyc(1, 8'hD1, 0, 0, 0);
        cyc(1, 8'hD2, 0, 0, 0);
        m_wr = 1'b1; m_din = 8'hD3; s_int_ack = 1'b0;
        @(posedge clk_sys);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        m_wr = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        cyc(1, 8'hE1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snd_mailbox.md
# snd_mailbox

Parametrised main-CPU → sound-CPU command mailbox for the arcade cores, succeeding the single-byte sound latch with change-detect NMI. It queues up to DEPTH commands written by the main 6502/68k side and presents them in order to the Z80 sound side. It drives a sound-CPU NMI that is acknowledged by the Z80 interrupt-acknowledge cycle (IORQ & M1). Overflow is reported, and an optional reply latch carries data back to the main CPU.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DW, 8: command width.
- NMI_REARM, 1: 1 = NMI re-raises after a pop if entries remain; 0 = NMI raised only by writes.
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush: empties FIFO, clears s_nmi and overflow.
- m_wr  in  1  main-side write strobe; one clk_sys cycle per write, already qualified by CPU clock enable.
- m_din  in  DW  command data.
- m_full  out  1  FIFO full.
- overflow  out  1  sticky; set when a write is dropped.
- s_rd  in  1  sound-side pop strobe; one cycle per read.
- s_dout  out  DW  current head entry (registered).
- s_empty  out  1  FIFO empty.
- s_nmi  out  1  active-high NMI request to the sound CPU; invert at the T80 NMI_n pin.
- s_int_ack  in  1  single-cycle pulse on IORQ & M1 low.
- count  out  $clog2(DEPTH+1)  current occupancy.
- Reply ports, present only under the macro: r_wr in 1, r_din in DW, m_rd in 1, m_rdata out DW, m_reply_valid out 1.

## Operation
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is held separately, range 0..DEPTH.
- Write accepted when m_wr and (count<DEPTH, or s_rd pops in the same cycle).
- Write when full with no pop: data dropped, pointers unchanged, overflow←1.
- Pop when s_rd and count>0: rd_ptr advances. s_rd on empty is ignored; s_dout holds its last value.
- Simultaneous write and pop:
  - count>0: both occur, count unchanged.
  - count=0: write only; the read is ignored.
- s_dout always shows the entry at rd_ptr when non-empty, otherwise the last popped value.
- s_nmi priority, highest first:
  1. Set on an accepted write.
  2. Set on a pop leaving count≥1, when NMI_REARM=1.
  3. Clear on s_int_ack.
  - Set wins over a same-cycle s_int_ack.
- clr outranks all other inputs in its cycle; same-cycle writes and reads are discarded.
- Reset values:
  - count=0, s_empty=1, m_full=0, s_nmi=0, overflow=0, s_dout=0, pointers=0.
  - With the macro: m_rdata=0, m_reply_valid=0.

## Timing
- Write accepted in cycle N → count, s_empty, m_full, s_nmi and s_dout (if the FIFO was empty) update at N+1.
- Pop in N → new head on s_dout at N+1.
- s_int_ack in N → s_nmi low at N+1, unless a set condition also occurs in N.
- Every input is sampled once per clk_sys edge; strobes held high for k cycles act k times.
- Reset asserted mid-operation clears all state immediately (asynchronous). Deassertion takes effect on the next clk_sys edge.

## Configuration
- SND_MAILBOX_REPLY_EN defined:
  - Adds a 1-entry reply latch. r_wr loads r_din into m_rdata and sets m_reply_valid at N+1.
  - m_rd clears m_reply_valid at N+1; m_rdata holds its value.
  - r_wr and m_rd in the same cycle: valid stays 1 and new data is loaded.
- Macro undefined: reply ports and logic are absent; the forward path is unchanged.

## Structure
- Package snd_mailbox_pkg holds:
  - function clog2_depth;
  - localparam type/width helpers for count and pointers;
  - an NMI priority enum (NMI_SET_WR, NMI_SET_REARM, NMI_CLR_ACK) for documentation and assertions.
- One sub-module, mailbox_fifo: storage array, pointers, count, full/empty, overflow.
- snd_mailbox adds the NMI state register, clr and reset handling, and the optional reply latch.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 → count=3, s_dout=0x11, s_nmi=1 at N+1; three pops return 0x11, 0x22, 0x33, then s_empty=1.
- DEPTH=4: five writes with no pops → m_full=1 after the fourth write, fifth (0x55) dropped, overflow=1; pops return only the first four values.
- Full FIFO, m_wr=0xAA with s_rd in the same cycle → count stays 4; the tail after three more pops is 0xAA; overflow stays 0.
- NMI_REARM=1, two entries: s_int_ack → s_nmi=0; s_rd → s_nmi=1 at next cycle. With NMI_REARM=0 the same sequence leaves s_nmi=0. s_int_ack together with m_wr → s_nmi stays 1.
- Pointer wrap: 10 write/pop pairs through DEPTH=4 with data 0..9 → output order 0..9; clr with 2 entries → count=0, s_nmi=0 next cycle.
- SND_MAILBOX_REPLY_EN: r_wr 0x5A → m_rdata=0x5A, m_reply_valid=1; m_rd → valid=0. Reset asserted mid-burst → all outputs return to reset values asynchronously.
